// File: rtl/uut_bench_sequencer_if.sv
// Stimulus and report channel between the SD-card loader and the bench sequencer.
interface uut_bench_sequencer_if #(
  parameter int IN_W  = 128,
  parameter int OUT_W = 128,
  parameter int CNT_W = 32
);
  logic [IN_W-1:0]  in_data_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [OUT_W-1:0] res_data_o;
  logic [CNT_W-1:0] cyc_last_o;
  logic [CNT_W-1:0] cyc_min_o;
  logic [CNT_W-1:0] cyc_max_o;
  logic             timeout_o;
  logic             mismatch_o;
  logic             res_valid_o;
  logic             res_ready_i;

  modport master (
    output in_data_i, in_valid_i, res_ready_i,
    input  in_ready_o, res_data_o, cyc_last_o, cyc_min_o, cyc_max_o,
           timeout_o, mismatch_o, res_valid_o
  );

  modport slave (
    input  in_data_i, in_valid_i, res_ready_i,
    output in_ready_o, res_data_o, cyc_last_o, cyc_min_o, cyc_max_o,
           timeout_o, mismatch_o, res_valid_o
  );
endinterface

// File: rtl/uut_bench_sequencer.sv
// On-FPGA test sequencer: latches one stimulus, runs the UUT RUNS times with a
// reset pulse before each run, and reports output plus cycle statistics.
module uut_bench_sequencer #(
  parameter int IN_W       = 128,
  parameter int OUT_W      = 128,
  parameter int CNT_W      = 32,
  parameter int RST_CYCLES = 4,
  parameter int TIMEOUT    = 1048576,
  parameter int RUNS       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  uut_bench_sequencer_if.slave bus,
  output logic [IN_W-1:0]      uut_data_o,
  output logic                 uut_rst_o,
  output logic                 uut_clk_en_o,
  input  logic                 uut_end_i,
  input  logic [OUT_W-1:0]     uut_out_i,
  output logic                 busy_o,
  input  logic [1:0]           sw_debug_i,
  output logic [31:0]          debug_o
);

  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RST    = 3'd1,
    S_RUN    = 3'd2,
    S_CAP    = 3'd3,
    S_REPORT = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [RCW-1:0]   rcnt_q, rcnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [11:0]      run_idx_q, run_idx_d;
  logic [IN_W-1:0]  data_q, data_d;
  logic [OUT_W-1:0] res_q, res_d;
  logic [OUT_W-1:0] ref_q, ref_d;
  logic [CNT_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] min_q, min_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic             tmo_q, tmo_d;
  logic             mis_q, mis_d;

  // State and datapath registers; reset aborts any run and holds the UUT in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rcnt_q    <= '0;
      cnt_q     <= '0;
      cyc_q     <= '0;
      run_idx_q <= '0;
      data_q    <= '0;
      res_q     <= '0;
      ref_q     <= '0;
      last_q    <= '0;
      min_q     <= '0;
      max_q     <= '0;
      tmo_q     <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rcnt_q    <= rcnt_d;
      cnt_q     <= cnt_d;
      cyc_q     <= cyc_d;
      run_idx_q <= run_idx_d;
      data_q    <= data_d;
      res_q     <= res_d;
      ref_q     <= ref_d;
      last_q    <= last_d;
      min_q     <= min_d;
      max_q     <= max_d;
      tmo_q     <= tmo_d;
      mis_q     <= mis_d;
    end
  end

  // Next-state and statistics update.
  always_comb begin
    state_d   = state_q;
    rcnt_d    = rcnt_q;
    cnt_d     = cnt_q;
    cyc_d     = cyc_q;
    run_idx_d = run_idx_q;
    data_d    = data_q;
    res_d     = res_q;
    ref_d     = ref_q;
    last_d    = last_q;
    min_d     = min_q;
    max_d     = max_q;
    tmo_d     = tmo_q;
    mis_d     = mis_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid_i) begin
          data_d    = bus.in_data_i;
          res_d     = '0;
          last_d    = '0;
          min_d     = '0;
          max_d     = '0;
          tmo_d     = 1'b0;
          mis_d     = 1'b0;
          run_idx_d = '0;
          rcnt_d    = '0;
          state_d   = S_RST;
        end
      end
      S_RST: begin
        if (rcnt_q == RCW'(RST_CYCLES - 1)) begin
          cnt_d   = CNT_W'(1);
          state_d = S_RUN;
        end else begin
          rcnt_d = rcnt_q + RCW'(1);
        end
      end
      S_RUN: begin
        // End has priority over the timeout on the same cycle.
        if (uut_end_i) begin
          cyc_d   = cnt_q;
          state_d = S_CAP;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          cyc_d   = CNT_W'(TIMEOUT);
          tmo_d   = 1'b1;
          state_d = S_CAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CAP: begin
        res_d  = uut_out_i;
        last_d = cyc_q;
        if (run_idx_q == '0) begin
          min_d = cyc_q;
          max_d = cyc_q;
          ref_d = uut_out_i;
        end else begin
          if (cyc_q < min_q) min_d = cyc_q;
          if (cyc_q > max_q) max_d = cyc_q;
          if (uut_out_i != ref_q) mis_d = 1'b1;
        end
        if (tmo_q || run_idx_q == 12'(RUNS - 1)) begin
          state_d = S_REPORT;
        end else begin
          run_idx_d = run_idx_q + 12'd1;
          rcnt_d    = '0;
          state_d   = S_RST;
        end
      end
      S_REPORT: begin
        if (bus.res_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready_o  = (state_q == S_IDLE) && !rst;
  assign bus.res_valid_o = (state_q == S_REPORT);
  assign bus.res_data_o  = res_q;
  assign bus.cyc_last_o  = last_q;
  assign bus.cyc_min_o   = min_q;
  assign bus.cyc_max_o   = max_q;
  assign bus.timeout_o   = tmo_q;
  assign bus.mismatch_o  = mis_q;
  assign uut_data_o      = data_q;
  assign uut_rst_o       = (state_q == S_IDLE) || (state_q == S_RST);
  assign uut_clk_en_o    = (state_q == S_RST) || (state_q == S_RUN);
  assign busy_o          = (state_q != S_IDLE);

  // Seven-segment debug word selection.
  always_comb begin
    debug_o = '0;
    case (sw_debug_i)
      2'd0: debug_o = res_q[31:0];
      2'd1: debug_o = 32'(last_q);
      2'd2: debug_o = 32'(max_q);
      default: debug_o = {1'b0, state_q, run_idx_q, 13'b0, mis_q, tmo_q, bus.res_valid_o};
    endcase
  end

endmodule

// File: tb/tb_uut_bench_sequencer.sv
// Directed bench for uut_bench_sequencer with a latency-programmable UUT model.
module tb_uut_bench_sequencer;

  localparam logic [127:0] A  = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] B  = 128'hFEDCBA9876543210DEADBEEFCAFEF00D;
  localparam logic [127:0] D1 = 128'h11112222333344445555666677778888;
  localparam logic [127:0] D2 = 128'h9999AAAABBBBCCCCDDDDEEEEFFFF0000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] uut_data;
  logic         uut_rst, uut_clk_en, uut_end;
  logic [127:0] uut_out;
  logic         busy;
  logic [1:0]   sw_debug = 2'd0;
  logic [31:0]  debug;

  int n_chk = 0;
  int n_err = 0;

  // UUT model state
  int           m = 0;
  int           r = 0;
  int           lat [4];
  logic [127:0] outs [4];

  uut_bench_sequencer_if #(.IN_W(128), .OUT_W(128), .CNT_W(32)) bus ();

  uut_bench_sequencer #(
    .IN_W(128), .OUT_W(128), .CNT_W(32),
    .RST_CYCLES(4), .TIMEOUT(64), .RUNS(4)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .uut_data_o(uut_data), .uut_rst_o(uut_rst), .uut_clk_en_o(uut_clk_en),
    .uut_end_i(uut_end), .uut_out_i(uut_out), .busy_o(busy),
    .sw_debug_i(sw_debug), .debug_o(debug)
  );

  always #5 clk = ~clk;

  // m counts enabled UUT cycles since reset release; r counts CAP cycles since handshake.
  always @(posedge clk) begin
    if (uut_rst) m <= 0;
    else if (uut_clk_en) m <= m + 1;
    if (bus.in_valid_i && bus.in_ready_o) r <= 0;
    else if (busy && !uut_rst && !uut_clk_en && !bus.res_valid_o) r <= r + 1;
  end

  always_comb begin
    uut_end = (lat[r % 4] != 0) && (m == lat[r % 4] - 1);
    uut_out = outs[r % 4];
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_uut(input int l0, l1, l2, l3, input logic [127:0] o0, o1, o2, o3);
    lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3;
    outs[0] = o0; outs[1] = o1; outs[2] = o2; outs[3] = o3;
  endtask

  task automatic send(input logic [127:0] d);
    @(negedge clk);
    bus.in_data_i  = d;
    bus.in_valid_i = 1'b1;
    @(posedge clk);
    #1 bus.in_valid_i = 1'b0;
  endtask

  task automatic wait_report();
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (bus.res_valid_o) break;
    end
    check("report_reached", bus.res_valid_o, 1);
  endtask

  task automatic ack();
    @(negedge clk);
    bus.res_ready_i = 1'b1;
    @(negedge clk);
    bus.res_ready_i = 1'b0;
  endtask

  task automatic dbg(input string tag, input logic [1:0] sel, input logic [31:0] exp);
    sw_debug = sel;
    #1 check(tag, debug, exp);
  endtask

  initial begin
    int rep_c, hs_c, bad;
    bus.in_data_i   = '0;
    bus.in_valid_i  = 1'b0;
    bus.res_ready_i = 1'b0;
    set_uut(10, 10, 10, 10, A, A, A, A);

    // Reset values
    #1;
    check("rst_uut_rst", uut_rst, 1);
    check("rst_clk_en", uut_clk_en, 0);
    check("rst_in_ready", bus.in_ready_o, 0);
    check("rst_res_valid", bus.res_valid_o, 0);
    check("rst_busy", busy, 0);
    check("rst_res_data", bus.res_data_o, 0);
    dbg("rst_debug3", 2'd3, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 check("rel_in_ready", bus.in_ready_o, 1);

    // 1: latency 10 each run, stimulus timing
    send(D1);
    @(negedge clk);
    check("t1_rst_first", uut_rst, 1);
    check("t1_clk_en", uut_clk_en, 1);
    check("t1_in_ready", bus.in_ready_o, 0);
    check("t1_uut_data", uut_data, D1);
    repeat (3) @(negedge clk);
    check("t1_rst_last", uut_rst, 1);
    @(negedge clk);
    check("t1_run_rst", uut_rst, 0);
    check("t1_run_en", uut_clk_en, 1);
    wait_report();
    check("t1_last", bus.cyc_last_o, 10);
    check("t1_min", bus.cyc_min_o, 10);
    check("t1_max", bus.cyc_max_o, 10);
    check("t1_data", bus.res_data_o, A);
    check("t1_tmo", bus.timeout_o, 0);
    check("t1_mis", bus.mismatch_o, 0);
    dbg("t1_dbg0", 2'd0, 32'h89ABCDEF);
    dbg("t1_dbg1", 2'd1, 32'd10);
    repeat (3) @(negedge clk);
    check("t1_hold_valid", bus.res_valid_o, 1);
    check("t1_hold_last", bus.cyc_last_o, 10);
    ack();
    check("t1_idle", busy, 0);

    // 2: varying latencies
    set_uut(12, 9, 15, 9, B, B, B, B);
    send(D2);
    wait_report();
    check("t2_min", bus.cyc_min_o, 9);
    check("t2_max", bus.cyc_max_o, 15);
    check("t2_last", bus.cyc_last_o, 9);
    check("t2_mis", bus.mismatch_o, 0);
    check("t2_runs", r, 4);
    dbg("t2_dbg3", 2'd3, 32'h4003_0001);
    dbg("t2_dbg2", 2'd2, 32'd15);
    ack();

    // 3: run 2 output has bit 5 flipped
    set_uut(5, 5, 5, 5, A, A, A ^ 128'h20, A);
    send(D1);
    wait_report();
    check("t3_mis", bus.mismatch_o, 1);
    check("t3_data", bus.res_data_o, A);
    repeat (2) @(negedge clk);
    check("t3_mis_hold", bus.mismatch_o, 1);
    dbg("t3_dbg3", 2'd3, 32'h4003_0005);
    ack();

    // 4a: UUT never ends
    set_uut(0, 0, 0, 0, B, B, B, B);
    send(D2);
    wait_report();
    check("t4_tmo", bus.timeout_o, 1);
    check("t4_last", bus.cyc_last_o, 64);
    check("t4_runs", r, 1);
    dbg("t4_dbg3", 2'd3, 32'h4000_0003);
    ack();

    // 4b: end exactly at cnt == TIMEOUT
    set_uut(64, 64, 64, 64, A, A, A, A);
    send(D1);
    wait_report();
    check("t4b_tmo", bus.timeout_o, 0);
    check("t4b_last", bus.cyc_last_o, 64);
    check("t4b_max", bus.cyc_max_o, 64);
    ack();

    // 5: reset during RUN of run 1
    set_uut(20, 20, 20, 20, B, B, B, B);
    send(D2);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (r == 1 && !uut_rst && uut_clk_en) break;
    end
    check("t5_in_run1", {r == 1, uut_rst, uut_clk_en}, 3'b101);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5_uut_rst", uut_rst, 1);
    check("t5_clk_en", uut_clk_en, 0);
    check("t5_valid", bus.res_valid_o, 0);
    check("t5_busy", busy, 0);
    check("t5_last", bus.cyc_last_o, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("t5_ready", bus.in_ready_o, 1);
    set_uut(7, 7, 7, 7, A, A, A, A);
    send(D1);
    wait_report();
    check("t5_new_last", bus.cyc_last_o, 7);
    check("t5_new_min", bus.cyc_min_o, 7);
    check("t5_new_max", bus.cyc_max_o, 7);
    dbg("t5_dbg3", 2'd3, 32'h4003_0001);
    ack();

    // 6: back-to-back with valid and ready held high
    set_uut(3, 3, 3, 3, B, B, B, B);
    @(negedge clk);
    bus.in_data_i   = D1;
    bus.in_valid_i  = 1'b1;
    bus.res_ready_i = 1'b1;
    rep_c = -1; hs_c = -1; bad = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (busy && bus.in_ready_o) bad++;
      if (bus.res_valid_o && rep_c < 0) rep_c = c;
      if (bus.in_ready_o && rep_c >= 0 && hs_c < 0) begin
        hs_c = c;
        bus.in_data_i = D2;
        break;
      end
    end
    check("t6_hs_found", hs_c >= 0, 1);
    check("t6_hs_delay", hs_c - rep_c, 1);
    check("t6_ready_busy", bad, 0);
    @(negedge clk);
    bus.in_valid_i  = 1'b0;
    bus.res_ready_i = 1'b0;
    check("t6_data2", uut_data, D2);
    check("t6_busy2", busy, 1);
    wait_report();
    check("t6_last", bus.cyc_last_o, 3);
    ack();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
